bin_to_bcd_seq: RTL
===================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter WIDTH, default 16, is the binary input width; legal range 4..32.
REQ-002 Parameter DIGITS, default 5, is the number of BCD output digits; legal range 1..10.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  in_data holds a value to convert.
REQ-006 in_ready  output  1  block can accept a new value.
REQ-007 in_data  input  WIDTH  binary operand.
REQ-008 out_valid  output  1  out_bcd, out_ovf and out_neg hold a finished result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in [3:0], digit k in [4k+3:4k].
REQ-011 out_ovf  output  1  result magnitude exceeded 10^DIGITS-1.
REQ-012 out_neg  output  1  result is negative; meaningful only with BCD_SIGNED_EN.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 IDLE SHALL drive in_ready=1; SHIFT and DONE SHALL drive in_ready=0.
REQ-015 A value SHALL be accepted on an edge where in_valid=1 and in_ready=1; the operand is latched, the digit register is cleared, the bit counter is loaded with WIDTH, out_ovf is cleared, and the state goes to SHIFT.
REQ-016 Each SHIFT edge SHALL perform one double-dabble step: add 3 to every digit >=5, then shift the {digits, operand} register left by one, with the operand MSB entering digit-0 bit 0.
REQ-017 If the bit shifted out of the top digit's MSB is 1 on any step, out_ovf SHALL be set and held until the next acceptance.
REQ-018 After exactly WIDTH SHIFT edges the state SHALL go to DONE, so out_valid rises WIDTH cycles after the acceptance edge.
REQ-019 DONE SHALL drive out_valid=1 and hold out_bcd, out_ovf and out_neg stable until an edge with out_ready=1, which returns the state to IDLE.
REQ-020 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-021 Throughput SHALL be one conversion per WIDTH+2 cycles when the consumer is always ready; DONE-to-IDLE and a new acceptance SHALL NOT occur on the same edge.
REQ-022 On overflow, out_bcd SHALL hold the low DIGITS digits of the true decimal result.
REQ-023 in_data=0 SHALL yield out_bcd=0, out_ovf=0, out_neg=0 after the full WIDTH-cycle latency, with no early exit.

Reset
REQ-024 While rst=1 on an edge, the state SHALL become IDLE, and out_bcd=0, out_ovf=0, out_neg=0 and out_valid=0, with in_ready=1 on the following cycle.
REQ-025 rst SHALL abort a conversion in SHIFT or DONE, and the partial or pending result SHALL be discarded.
REQ-026 rst SHALL take priority over every handshake on the same edge.

Configuration
REQ-027 When macro BCD_SIGNED_EN is defined, in_data SHALL be treated as two's complement: on acceptance, out_neg is set to in_data[WIDTH-1] and the operand is replaced by its magnitude (-2^(WIDTH-1) converts to 2^(WIDTH-1) unsigned).
REQ-028 When BCD_SIGNED_EN is undefined, in_data SHALL be treated as unsigned and out_neg SHALL be tied to 0.

Verification
REQ-029 WIDTH=16, DIGITS=5, unsigned: accept 65535 -> out_bcd digits 6,5,5,3,5 (0x65535), out_ovf=0, out_valid rises 16 cycles after acceptance.
REQ-030 WIDTH=10, DIGITS=3: accept 1023 -> out_ovf=1 and out_bcd=0x023; then accept 999 -> out_ovf=0 and out_bcd=0x999.
REQ-031 Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1 with outputs unchanged and in_ready stays 0; releasing out_ready gives IDLE on the next edge.
REQ-032 Pulse rst at SHIFT step 7 -> the next cycle shows in_ready=1 and out_valid=0; a fresh conversion of 42 yields 0x00042.
REQ-033 BCD_SIGNED_EN, WIDTH=16: accept -1234 (0xFB2E) -> out_neg=1, out_bcd=0x01234; accept -32768 -> out_neg=1, out_bcd=0x32768.
REQ-034 Back-to-back: hold in_valid=1 and out_ready=1 continuously -> acceptances spaced exactly WIDTH+2 cycles apart.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes on both sides.
// Optional macro BCD_SIGNED_EN: treat in_data as two's complement and report the sign on out_neg.
module bin_to_bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  out_ovf,
   output logic                  out_neg
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [WIDTH-1:0]     r_operand;
   logic [4*DIGITS-1:0]  r_bcd;
   logic [4*DIGITS-1:0]  w_adj;
   logic [CW-1:0]        r_cnt;
   logic                 r_ovf;
   logic                 w_accept;
   logic [WIDTH-1:0]     w_operand_in;

`ifdef BCD_SIGNED_EN
   logic                 r_neg;
   // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is correct as unsigned.
   assign w_operand_in = in_data[WIDTH-1] ? (~in_data + 1'b1) : in_data;
   assign out_neg      = r_neg;
`else
   assign w_operand_in = in_data;
   assign out_neg      = 1'b0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? (r_bcd[4*gi +: 4] + 4'd3)
                                                               : r_bcd[4*gi +: 4];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept     = 1'b1;
               w_state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (r_cnt == CW'(1)) w_state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_operand <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
`ifdef BCD_SIGNED_EN
         r_neg     <= 1'b0;
`endif
      end else if (w_accept) begin
         r_operand <= w_operand_in;
         r_bcd     <= '0;
         r_cnt     <= CW'(WIDTH);
         r_ovf     <= 1'b0;
`ifdef BCD_SIGNED_EN
         r_neg     <= in_data[WIDTH-1];
`endif
      end else if (r_state == SHIFT) begin
         // The adjusted top digit's MSB falls off the end; it is a decimal carry out of range.
         {r_bcd, r_operand} <= {w_adj[4*DIGITS-2:0], r_operand, 1'b0};
         r_ovf              <= r_ovf | w_adj[4*DIGITS-1];
         r_cnt              <= r_cnt - CW'(1);
      end
   end

   assign out_bcd = r_bcd;
   assign out_ovf = r_ovf;

endmodule
